// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Byte-serial instruction fetch with big-endian assembly, a
//            valid/ready decode interface and redirect with in-flight abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              misalign
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              misalign_q, misalign_d;
  logic              req_outstanding;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_PC;
      k_q        <= 2'd0;
      instr_q    <= 32'd0;
      instr_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      k_q        <= k_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
    end
  end

  // A read is still owed to us after this edge if we issue now, or if we are
  // waiting/draining and the response has not shown up yet.
  assign req_outstanding = (state_q == ST_ISSUE) ||
                           (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !mem_rd_valid);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    k_d        = k_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = redirect && (redirect_target[1:0] != 2'b00);

    case (state_q)
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rd_valid) begin
          // Lane 3-k holds byte k; for a 2-bit k that lane index is ~k.
          instr_d[{~k_q, 3'b000} +: 8] = mem_rd_data;
          if (k_q == 2'd3) begin
            state_d    = ST_HOLD;
            instr_pc_d = pc_q;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          k_d     = 2'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (mem_rd_valid) state_d = ST_ISSUE;
      end
      default: state_d = ST_ISSUE;
    endcase

    // Redirect overrides everything above; a response landing in DRAIN on the
    // same cycle retires the outstanding read, so we resume issuing.
    if (redirect) begin
      pc_d       = {redirect_target[ADDR_W-1:2], 2'b00};
      k_d        = 2'd0;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      state_d    = req_outstanding ? ST_DRAIN : ST_ISSUE;
    end
  end

  assign mem_rd_en   = Reset && (state_q == ST_ISSUE);
  assign mem_addr    = pc_q + ADDR_W'(k_q);
  assign instr_valid = (state_q == ST_HOLD);
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with a byte memory
//            responder and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          HMAX     = 8192;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_rd_valid;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              misalign;

  always #5 Clk = ~Clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .Clk(Clk), .Reset(Reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_target(redirect_target), .misalign(misalign)
  );

  int checks = 0;
  int failures = 0;

  // Per-cycle observation history used by the directed scenarios.
  logic        h_en  [HMAX];
  logic [31:0] h_addr[HMAX];
  logic        h_val [HMAX];
  logic [31:0] h_out [HMAX];
  logic [31:0] h_pc  [HMAX];
  logic        h_mis [HMAX];
  int          cur = 0;

  // Reference model: how many bytes of the current word are in hand, whether a
  // read is in flight and whether its data is to be thrown away.
  logic [31:0] m_pc, m_word, m_ipc;
  int          m_got;
  logic        m_out, m_disc, m_mis;
  logic        m_init = 1'b0;

  // Memory responder.
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_a;
  logic        resp_now = 1'b0;
  int          fixed_lat = 1;
  logic        rand_mode = 1'b0;
  int          n_acc = 0;
  int          last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] t;
    case (a)
      32'd0:   mem_byte = 8'h24;
      32'd1:   mem_byte = 8'h01;
      32'd2:   mem_byte = 8'h00;
      32'd3:   mem_byte = 8'h2C;
      default: begin
        t = a[7:0] * 8'd7;
        mem_byte = (t + 8'h13) ^ a[31:24] ^ a[15:8];
      end
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       pick_target = 32'($urandom_range(0, 255));
      1:       pick_target = $urandom;
      2:       pick_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: pick_target = 32'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic cycle();
    logic exp_en;
    logic issue;
    @(negedge Clk);
    if (cur < HMAX) begin
      h_en[cur] = mem_rd_en;  h_addr[cur] = mem_addr; h_val[cur] = instr_valid;
      h_out[cur] = instr_out; h_pc[cur] = instr_pc;   h_mis[cur] = misalign;
    end
    if (m_init) begin
      exp_en = Reset && !m_out && (m_got < 4);
      chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_en});
      if (exp_en || (m_out && !m_disc)) chk("mem_addr", mem_addr, m_pc + 32'(m_got));
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_got == 4});
      if (m_got == 4) begin
        chk("instr_out", instr_out, m_word);
        chk("instr_pc", instr_pc, m_ipc);
      end
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
      chk("no_x", {31'd0, $isunknown({mem_addr, mem_rd_en, instr_out, instr_pc, instr_valid, misalign})}, 32'd0);
      if (instr_valid && instr_ready && Reset) begin
        chk("accepted_word", instr_out, mem_word(instr_pc));
        n_acc++;
        last_acc = cur;
      end
    end
    if (!Reset) last_acc = cur;

    if (resp_now) mem_pend = 1'b0;
    if (!Reset && mem_pend && mem_cnt > 1) mem_pend = 1'b0;
    if (mem_rd_en === 1'b1) begin
      chk("one_outstanding", {31'd0, mem_pend}, 32'd0);
      mem_pend = 1'b1;
      mem_a    = mem_addr;
      mem_cnt  = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
    end

    if (!Reset) begin
      m_pc = RESET_PC; m_got = 0; m_word = 32'd0; m_ipc = RESET_PC;
      m_out = 1'b0; m_disc = 1'b0; m_mis = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      issue = !m_out && (m_got < 4);
      m_mis = redirect && (redirect_target[1:0] != 2'b00);
      if (redirect) begin
        m_pc  = {redirect_target[31:2], 2'b00};
        m_got = 0;
        if (issue) begin
          m_out = 1'b1; m_disc = 1'b1;
        end else if (m_out) begin
          if (mem_rd_valid) begin m_out = 1'b0; m_disc = 1'b0; end
          else m_disc = 1'b1;
        end
      end else if (issue) begin
        m_out = 1'b1; m_disc = 1'b0;
      end else if (m_out && mem_rd_valid) begin
        m_out = 1'b0;
        if (m_disc) m_disc = 1'b0;
        else begin
          m_word[8*(3-m_got) +: 8] = mem_rd_data;
          m_got++;
          if (m_got == 4) m_ipc = m_pc;
        end
      end else if (m_got == 4 && instr_ready) begin
        m_pc  = m_pc + 32'd4;
        m_got = 0;
      end
    end

    @(posedge Clk);
    #1;
    cur++;
    redirect     = 1'b0;
    resp_now     = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 8'($urandom);
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = mem_byte(mem_a);
        resp_now     = 1'b1;
      end
    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
      mem_rd_valid = 1'b1;
    end
    if (rand_mode) begin
      Reset       = ($urandom_range(0, 299) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect        = 1'b1;
        redirect_target = pick_target();
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    cycle();
    Reset = 1'b1;
  endtask

  initial begin
    int c0;
    int c1r;
    Reset = 1'b0; redirect = 1'b0; redirect_target = '0; instr_ready = 1'b1;
    mem_rd_valid = 1'b0; mem_rd_data = 8'd0;
    cycle();

    // Basic fetch from reset with single-cycle memory.
    do_reset(); c0 = cur; instr_ready = 1'b1; fixed_lat = 1;
    repeat (10) cycle();
    chk("t1_rst_out", h_out[c0], 32'd0);
    chk("t1_rst_pc", h_pc[c0], RESET_PC);
    chk("t1_rst_mis", {31'd0, h_mis[c0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_en_issue", {31'd0, h_en[c0+2*i]}, 32'd1);
      chk("t1_addr", h_addr[c0+2*i], 32'(i));
      chk("t1_en_wait", {31'd0, h_en[c0+2*i+1]}, 32'd0);
    end
    chk("t1_valid_c7", {31'd0, h_val[c0+7]}, 32'd0);
    chk("t1_valid_c8", {31'd0, h_val[c0+8]}, 32'd1);
    chk("t1_word", h_out[c0+8], 32'h2401002C);
    chk("t1_pc", h_pc[c0+8], 32'd0);
    chk("t1_next_en", {31'd0, h_en[c0+9]}, 32'd1);
    chk("t1_next_addr", h_addr[c0+9], 32'd4);

    // Decode stalls for five cycles in HOLD.
    do_reset(); c0 = cur; instr_ready = 1'b0;
    repeat (13) cycle();
    instr_ready = 1'b1;
    repeat (2) cycle();
    for (int i = 8; i < 14; i++) begin
      chk("t2_hold_valid", {31'd0, h_val[c0+i]}, 32'd1);
      chk("t2_hold_word", h_out[c0+i], 32'h2401002C);
      chk("t2_hold_pc", h_pc[c0+i], 32'd0);
      chk("t2_hold_no_en", {31'd0, h_en[c0+i]}, 32'd0);
    end
    chk("t2_next_en", {31'd0, h_en[c0+14]}, 32'd1);
    chk("t2_next_addr", h_addr[c0+14], 32'd4);

    // Redirect while byte 2 is delayed: drain and refetch at 0x18.
    do_reset(); c0 = cur; instr_ready = 1'b1; fixed_lat = 1;
    repeat (4) cycle();
    fixed_lat = 3;
    cycle();
    fixed_lat = 1; redirect = 1'b1; redirect_target = 32'h18;
    repeat (12) cycle();
    chk("t3_drain_no_en6", {31'd0, h_en[c0+6]}, 32'd0);
    chk("t3_drain_no_en7", {31'd0, h_en[c0+7]}, 32'd0);
    chk("t3_restart_en", {31'd0, h_en[c0+8]}, 32'd1);
    chk("t3_restart_addr", h_addr[c0+8], 32'h18);
    chk("t3_valid_c15", {31'd0, h_val[c0+15]}, 32'd0);
    chk("t3_valid_c16", {31'd0, h_val[c0+16]}, 32'd1);
    chk("t3_word", h_out[c0+16], 32'hBBC2C9D0);
    chk("t3_pc", h_pc[c0+16], 32'h18);

    // Misaligned redirect in HOLD with a simultaneous handshake.
    do_reset(); c0 = cur; instr_ready = 1'b1; fixed_lat = 1;
    repeat (8) cycle();
    redirect = 1'b1; redirect_target = 32'h21;
    repeat (10) cycle();
    chk("t4_hold_valid", {31'd0, h_val[c0+8]}, 32'd1);
    chk("t4_mis_c8", {31'd0, h_mis[c0+8]}, 32'd0);
    chk("t4_mis_c9", {31'd0, h_mis[c0+9]}, 32'd1);
    chk("t4_mis_c10", {31'd0, h_mis[c0+10]}, 32'd0);
    chk("t4_restart_en", {31'd0, h_en[c0+9]}, 32'd1);
    chk("t4_restart_addr", h_addr[c0+9], 32'h20);
    chk("t4_word", h_out[c0+17], 32'hF3FA0108);
    chk("t4_pc", h_pc[c0+17], 32'h20);

    // Reset during WAIT of byte 1 with the response arriving after reset.
    do_reset(); c0 = cur; instr_ready = 1'b1; fixed_lat = 1;
    repeat (2) cycle();
    fixed_lat = 2;
    cycle();
    Reset = 1'b0; fixed_lat = 1;
    cycle();
    Reset = 1'b1; c1r = cur;
    repeat (9) cycle();
    chk("t5_valid_after_rst", {31'd0, h_val[c1r]}, 32'd0);
    chk("t5_en_after_rst", {31'd0, h_en[c1r]}, 32'd1);
    chk("t5_addr_after_rst", h_addr[c1r], RESET_PC);
    chk("t5_out_after_rst", h_out[c1r], 32'd0);
    chk("t5_pc_after_rst", h_pc[c1r], RESET_PC);
    chk("t5_word", h_out[c1r+8], 32'h2401002C);
    chk("t5_valid", {31'd0, h_val[c1r+8]}, 32'd1);

    // PC wrap at the top of the address space.
    do_reset(); c0 = cur; instr_ready = 1'b0; fixed_lat = 1;
    cycle();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    repeat (9) cycle();
    instr_ready = 1'b1;
    repeat (2) cycle();
    chk("t6_mis", {31'd0, h_mis[c0+2]}, 32'd1);
    chk("t6_addr_top", h_addr[c0+2], 32'hFFFF_FFFC);
    chk("t6_valid", {31'd0, h_val[c0+10]}, 32'd1);
    chk("t6_word", h_out[c0+10], 32'hF7FE050C);
    chk("t6_pc", h_pc[c0+10], 32'hFFFF_FFFC);
    chk("t6_wrap_en", {31'd0, h_en[c0+11]}, 32'd1);
    chk("t6_wrap_addr", h_addr[c0+11], 32'd0);

    // Randomized traffic against the reference model.
    rand_mode = 1'b1; fixed_lat = 0; n_acc = 0; last_acc = cur;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (cur - last_acc > 500) begin
        checks++;
        failures++;
        $display("FAIL progress_watchdog actual=no_accept_for_%0d_cycles required=<=500", cur - last_acc);
        break;
      end
    end
    chk("rand_accepts", {31'd0, n_acc > 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
